// File: rtl/diad_trace_tx_pkg.sv
// ----------------------------------------------------------------------------
// diad_trace_tx_pkg : shared trace frame constants and serializer states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package diad_trace_tx_pkg;

  localparam logic [7:0] TRACE_SYNC        = 8'hA5;
  localparam int         TRACE_FRAME_BYTES = 12;
  localparam int         TRACE_FRAME_W     = TRACE_FRAME_BYTES * 8;
  localparam logic [3:0] TRACE_NO_GP       = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/diad_trace_tx_fifo.sv
// ----------------------------------------------------------------------------
// diad_trace_tx_fifo : synchronous record FIFO, head visible on o_rdata
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module diad_trace_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/diad_trace_tx.sv
// ----------------------------------------------------------------------------
// diad_trace_tx : WB retirement capture, record FIFO and 12-byte frame serializer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module diad_trace_tx
  import diad_trace_tx_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PC_W    = 24,
  parameter int INSTR_W = 24,
  parameter int DATA_W  = 24
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_en,
  input  logic               iw_wb_valid,
  input  logic [PC_W-1:0]    iw_wb_pc,
  input  logic [INSTR_W-1:0] iw_wb_instr,
  input  logic [3:0]         iw_wb_tgt_gp,
  input  logic [DATA_W-1:0]  iw_wb_result,
  output logic [7:0]         ow_tx_data,
  output logic               ow_tx_valid,
  input  logic               iw_tx_ready,
  output logic [7:0]         ow_drop_cnt,
  output logic               ow_busy
);

  localparam int RES_LSB = 0;
  localparam int TGT_LSB = DATA_W;
  localparam int INS_LSB = TGT_LSB + 4;
  localparam int PC_LSB  = INS_LSB + INSTR_W;
  localparam int SEQ_LSB = PC_LSB + PC_W;
  localparam int REC_W   = SEQ_LSB + 8;

  tx_state_e                r_state;
  logic [TRACE_FRAME_W-1:0] r_shift;
  logic [3:0]               r_idx;
  logic [7:0]               r_seq;
  logic [7:0]               r_drop_cnt;

  logic                     w_offer;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_count;
  logic [REC_W-1:0]         w_rec_in;
  logic [REC_W-1:0]         w_rec_out;
  logic [TRACE_FRAME_W-1:0] w_frame;

  assign w_offer  = iw_en & iw_wb_valid;
  assign w_hs     = (r_state == ST_SEND) && iw_tx_ready;
  assign w_last   = (r_idx == 4'(TRACE_FRAME_BYTES - 1));
  assign w_pop    = !w_empty && ((r_state == ST_IDLE) || (w_hs && w_last));
  assign w_push   = w_offer && (!w_full || w_pop);
  assign w_rec_in = {r_seq, iw_wb_pc, iw_wb_instr, iw_wb_tgt_gp, iw_wb_result};

  diad_trace_tx_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (iw_clk),
    .i_rst_n (iw_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_rec_in),
    .o_rdata (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Fields are zero-extended to fixed 24-bit slots so the frame layout never moves.
  assign w_frame = {TRACE_SYNC,
                    w_rec_out[SEQ_LSB +: 8],
                    24'(w_rec_out[PC_LSB  +: PC_W]),
                    24'(w_rec_out[INS_LSB +: INSTR_W]),
                    4'h0, w_rec_out[TGT_LSB +: 4],
                    24'(w_rec_out[RES_LSB +: DATA_W])};

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_seq <= r_seq + 8'd1;
      end else if (w_offer && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_frame;
            r_idx   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (w_last && w_pop) begin
              r_shift <= w_frame;
              r_idx   <= '0;
            end else if (w_last) begin
              r_shift <= {r_shift[TRACE_FRAME_W-9:0], 8'h00};
              r_idx   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_shift <= {r_shift[TRACE_FRAME_W-9:0], 8'h00};
              r_idx   <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ow_tx_data  = r_shift[TRACE_FRAME_W-1 -: 8];
  assign ow_tx_valid = (r_state == ST_SEND);
  assign ow_drop_cnt = r_drop_cnt;
  assign ow_busy     = (w_count != '0) || (r_state == ST_SEND);

endmodule

`default_nettype wire

// File: tb/tb_diad_trace_tx.sv
// ----------------------------------------------------------------------------
// tb_diad_trace_tx : scoreboard bench for the retirement trace transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_diad_trace_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        wb_valid = 1'b0;
  logic [23:0] wb_pc = '0;
  logic [23:0] wb_instr = '0;
  logic [3:0]  wb_tgt = '0;
  logic [23:0] wb_result = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  drop_cnt;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_seq = '0;
  int          mon_idx = 0;
  logic [7:0]  mon_last_seq = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always #5 clk = ~clk;

  diad_trace_tx #(
    .DEPTH   (8),
    .PC_W    (24),
    .INSTR_W (24),
    .DATA_W  (24)
  ) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_en        (en),
    .iw_wb_valid  (wb_valid),
    .iw_wb_pc     (wb_pc),
    .iw_wb_instr  (wb_instr),
    .iw_wb_tgt_gp (wb_tgt),
    .iw_wb_result (wb_result),
    .ow_tx_data   (tx_data),
    .ow_tx_valid  (tx_valid),
    .iw_tx_ready  (tx_ready),
    .ow_drop_cnt  (drop_cnt),
    .ow_busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [23:0] pc,
                            input logic [23:0] instr, input logic [3:0] tgt,
                            input logic [23:0] res);
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    exp_q.push_back(pc[23:16]);    exp_q.push_back(pc[15:8]);    exp_q.push_back(pc[7:0]);
    exp_q.push_back(instr[23:16]); exp_q.push_back(instr[15:8]); exp_q.push_back(instr[7:0]);
    exp_q.push_back({4'h0, tgt});
    exp_q.push_back(res[23:16]);   exp_q.push_back(res[15:8]);   exp_q.push_back(res[7:0]);
  endtask

  // Drive one WB retirement for one cycle; acc says whether it should be framed.
  task automatic offer(input logic [23:0] pc, input logic [23:0] instr,
                       input logic [3:0] tgt, input logic [23:0] res, input bit acc);
    wb_valid  = 1'b1;
    wb_pc     = pc;
    wb_instr  = instr;
    wb_tgt    = tgt;
    wb_result = res;
    if (acc) begin
      push_frame(m_seq, pc, instr, tgt, res);
      m_seq = m_seq + 8'd1;
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit bp);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < budget) begin
      if (bp) tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b1;
    check("drain_in_budget", 32'(cyc < budget), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_seq = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_data",  tx_data,  0);
    check("rst_drop",  drop_cnt, 0);
    check("rst_busy",  busy,     0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: byte-by-byte scoreboard, stall stability and mid-frame valid checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data",  tx_data,  prev_data);
      end
      if (mon_idx != 0) check("valid_mid_frame", tx_valid, 1);
      if (tx_valid && tx_ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("byte", tx_data, exp_q.pop_front());
        if (mon_idx == 1) mon_last_seq = tx_data;
        mon_idx = (mon_idx == 11) ? 0 : mon_idx + 1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    int rises;
    logic pv;
    int cyc;

    #2;
    do_reset();

    // Single record with first-byte latency.
    tx_ready = 1'b1;
    offer(24'h000010, 24'h123456, 4'h3, 24'h0000AB, 1);
    check("lat_not_yet", tx_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", tx_valid, 1);
    check("lat_sync",  tx_data,  8'hA5);
    wait_drain(100, 0);

    // Same record under 1,0,0,1 backpressure.
    offer(24'h000010, 24'h123456, 4'h3, 24'h0000AB, 1);
    wait_drain(200, 1);

    // Three back-to-back records: 36 contiguous valid cycles.
    vcount = 0; rises = 0; pv = 1'b0;
    fork
      begin
        offer(24'h000100, 24'hABCDEF, 4'hF, 24'h111111, 1);
        offer(24'h000104, 24'h000013, 4'h1, 24'h222222, 1);
        offer(24'h000108, 24'hFEDCBA, 4'h7, 24'h333333, 1);
      end
      begin
        repeat (50) begin
          @(negedge clk);
          if (tx_valid) vcount++;
          if (tx_valid && !pv) rises++;
          pv = tx_valid;
        end
      end
    join
    check("b2b_valid_cycles", vcount, 36);
    check("b2b_single_burst", rises, 1);
    wait_drain(100, 0);

    // Overflow: 12 offers with the sink stalled.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 12; i++)
      offer(24'h000200 + 24'(i * 4), 24'h00A000 + 24'(i), 4'(i), 24'h0F0000 + 24'(i), i < 9);
    @(posedge clk); #1;
    check("ovf_drop_cnt", drop_cnt, 3);
    check("ovf_busy",     busy,     1);
    check("ovf_valid",    tx_valid, 1);
    check("ovf_head",     tx_data,  8'hA5);
    tx_ready = 1'b1;
    wait_drain(300, 0);
    check("ovf_last_seq", mon_last_seq, 8'h08);
    check("ovf_drop_keep", drop_cnt, 3);

    // Disabled trace ignores records without counting drops.
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 5; i++) offer(24'(i), 24'(i), 4'h2, 24'(i), 0);
    repeat (20) @(posedge clk);
    #1;
    check("dis_drop",  drop_cnt, 0);
    check("dis_busy",  busy,     0);
    check("dis_valid", tx_valid, 0);
    en = 1'b1;

    // 257 records paced at the sustained rate: sequence wraps back to 00.
    for (int i = 0; i < 257; i++) begin
      offer(24'($urandom), 24'($urandom), 4'($urandom), 24'($urandom), 1);
      repeat (12) @(posedge clk);
      #1;
    end
    wait_drain(100, 0);
    check("wrap_last_seq", mon_last_seq, 8'h00);
    check("wrap_drop",     drop_cnt,     0);

    // Reset mid-frame.
    offer(24'h000010, 24'h123456, 4'h3, 24'h0000AB, 1);
    cyc = 0;
    while (mon_idx != 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_byte4", 32'(cyc < 40), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_data",  tx_data,  0);
    check("mid_rst_busy",  busy,     0);
    check("mid_rst_drop",  drop_cnt, 0);
    exp_q.delete();
    m_seq = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("mid_no_partial", tx_valid, 0);
    end
    offer(24'h000020, 24'h654321, 4'h5, 24'h00CDEF, 1);
    wait_drain(100, 0);
    check("mid_seq_restart", mon_last_seq, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
